// File: rtl/mem_bus_pkg.sv
// Shared constants and state encoding for the memory bus controller.
package mem_bus_pkg;
  localparam int MB_AW      = 16;
  localparam int MB_DW      = 16;
  localparam int MB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    XFER   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// Clearable saturating wait counter; flags the increment that reaches MAX.
module mem_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                           cnt_d = '0;
    else if (inc && cnt_q != CW'(MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = inc && !clr && (cnt_q == CW'(MAX - 1));
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: one read/write per request, MDB handoff to the MDR.
// Optional ACCESS timeout abort enabled by MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int AW      = MB_AW,
  parameter int DW      = MB_DW,
  parameter int TIMEOUT = MB_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mdr_load2,
  inout  wire  [DW-1:0] MDB,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          to_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_bus_ctrl: TIMEOUT must be at least 1");
  end

`ifdef MEM_BUS_TIMEOUT_EN
  // Held clear outside ACCESS, so every ACCESS entry starts from zero.
  mem_wait_timer #(.MAX(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ACCESS),
    .inc    ((state_q == ACCESS) && !mem_ack),
    .expire (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = addr;
        we_d    = we;
        state_d = ACCESS;
      end
      ACCESS: begin
        // An ack on the expiry cycle still completes the transfer normally.
        if (mem_ack) begin
          if (we_q) state_d = DONE;
          else begin
            rdata_d = mem_rdata;
            state_d = XFER;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      XFER:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign mdr_load2 = (state_q == XFER);
  assign mem_addr  = addr_q;
  assign mem_rd    = (state_q == ACCESS) && !we_q;
  assign mem_wr    = (state_q == ACCESS) && we_q;
  // Outside XFER the MDR owns MDB, so a write simply forwards the bus.
  assign MDB       = mdr_load2 ? rdata_q : {DW{1'bz}};
  assign mem_wdata = MDB;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized bench for mem_bus_ctrl with a transaction-timeline reference model.
module tb_mem_bus_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [15:0] addr, mem_rdata;
  wire         busy, done, err, mdr_load2, mem_rd, mem_wr;
  wire  [15:0] mem_addr, mem_wdata;
  wire  [15:0] MDB;

  logic        tb_drv, mdr_wr_en;
  logic [15:0] mdr, mdr_wr_val;

  mem_bus_ctrl #(.AW(16), .DW(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
    .busy(busy), .done(done), .err(err), .mdr_load2(mdr_load2), .MDB(MDB),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Bench-side MDR: drives MDB when asked, loads it on mdr_load2.
  assign MDB = tb_drv ? mdr : 16'hzzzz;
  always @(posedge clk) begin
    if (mdr_load2)      mdr <= MDB;
    else if (mdr_wr_en) mdr <= mdr_wr_val;
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        busy, rd, wr, load, done, err;
    logic [15:0] addr, mdb, wdata;
  } exp_t;
  exp_t exp_tab[int];

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0, wr_cnt = 0, load_cnt = 0, last_done = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  // Per-cycle compare against the timeline; cycles with no entry must be idle.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : '0;
      chk("busy", {31'd0, busy}, {31'd0, e.busy});
      chk("done", {31'd0, done}, {31'd0, e.done});
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("mdr_load2", {31'd0, mdr_load2}, {31'd0, e.load});
      chk("mem_rd", {31'd0, mem_rd}, {31'd0, e.rd});
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
      if (e.rd || e.wr) chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
      if (e.wr)         chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
      if (e.load)       chk("MDB", {16'd0, MDB}, {16'd0, e.mdb});
      if (tb_drv && mdr_load2) chk("bus_contention", 32'd1, 32'd0);
      if (done) begin done_cnt++; last_done = cyc; end
      if (err) err_cnt++;
      if (mem_rd) rd_cnt++;
      if (mem_wr) wr_cnt++;
      if (mdr_load2) load_cnt++;
    end
  end

  task automatic set_mdr(input logic [15:0] v);
    mdr_wr_en = 1'b1; mdr_wr_val = v; req = 1'b0;
    @(posedge clk); #1;
    mdr_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req = 1'b0; mem_ack = 1'($urandom % 2); mem_rdata = 16'($urandom);
    end
  endtask

  // Called #1 after a rising edge; returns in the first IDLE cycle afterwards.
  task automatic xact(input logic w, input logic [15:0] a, input logic [15:0] rd,
                      input int k, input bit stray, output int c0);
    int   acc, end_c;
    bit   tmo;
    exp_t r;
    c0 = cyc; acc = k; tmo = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    if (k > TO) begin acc = TO; tmo = 1'b1; end
`endif
    req = 1'b1; we = w; addr = a; tb_drv = w;
    for (int i = 1; i <= acc; i++) begin
      r = '0; r.busy = 1'b1; r.rd = !w; r.wr = w; r.addr = a; r.wdata = mdr;
      exp_tab[c0 + i] = r;
    end
    if (tmo) begin
      r = '0; r.busy = 1'b1; r.done = 1'b1; r.err = 1'b1;
      end_c = c0 + acc + 1; exp_tab[end_c] = r;
    end else if (!w) begin
      r = '0; r.busy = 1'b1; r.load = 1'b1; r.mdb = rd;
      exp_tab[c0 + acc + 1] = r;
      r = '0; r.busy = 1'b1; r.done = 1'b1;
      end_c = c0 + acc + 2; exp_tab[end_c] = r;
    end else begin
      r = '0; r.busy = 1'b1; r.done = 1'b1;
      end_c = c0 + acc + 1; exp_tab[end_c] = r;
    end
    while (cyc < end_c) begin
      @(posedge clk); #1;
      req  = stray ? 1'($urandom % 2) : 1'b0;
      we   = 1'($urandom % 2);
      addr = stray ? 16'h0002 : 16'($urandom);
      if (cyc <= c0 + acc) mem_ack = !tmo && (cyc == c0 + k);
      else                 mem_ack = 1'($urandom % 2);
      mem_rdata = mem_ack && (cyc == c0 + k) ? rd : 16'($urandom);
    end
    @(posedge clk); #1;
    req = 1'b0; mem_ack = 1'b0; tb_drv = 1'b0;
  endtask

  initial begin
    int   c0, d0, r0, w0, l0, e0;
    logic [15:0] v, m0;
    exp_t r;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    tb_drv = 1'b0; mdr_wr_en = 1'b0; mdr_wr_val = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_load", {31'd0, mdr_load2}, 32'd0);
    chk("rst_rdwr", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    set_mdr(16'h5A5A);

    // Zero-wait read.
    d0 = done_cnt; r0 = rd_cnt; l0 = load_cnt;
    xact(1'b0, 16'h0040, 16'hBEEF, 1, 1'b0, c0);
    chk("rd_done_lat", last_done - c0, 32'd3);
    chk("rd_strobes", rd_cnt - r0, 32'd1);
    chk("rd_loads", load_cnt - l0, 32'd1);
    chk("rd_mdr", {16'd0, mdr}, 32'h0000BEEF);
    chk("rd_dones", done_cnt - d0, 32'd1);

    // Write with three wait states.
    set_mdr(16'h1234);
    w0 = wr_cnt; l0 = load_cnt;
    xact(1'b1, 16'h00A0, 16'h0, 3, 1'b0, c0);
    chk("wr_done_lat", last_done - c0, 32'd4);
    chk("wr_strobes", wr_cnt - w0, 32'd3);
    chk("wr_loads", load_cnt - l0, 32'd0);
    chk("wr_mdr", {16'd0, mdr}, 32'h00001234);

    // Requests while busy are dropped.
    d0 = done_cnt;
    xact(1'b0, 16'h0100, 16'h0F0F, 3, 1'b1, c0);
    idle(2);
    chk("busy_req_dones", done_cnt - d0, 32'd1);

    // Async reset during XFER.
    d0 = done_cnt; m0 = mdr; c0 = cyc;
    req = 1'b1; we = 1'b0; addr = 16'h0055;
    r = '0; r.busy = 1'b1; r.rd = 1'b1; r.addr = 16'h0055; exp_tab[c0 + 1] = r;
    @(posedge clk); #1 req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(posedge clk); #1 mem_ack = 1'b0;
    chk("xfer_pre_rst", {31'd0, mdr_load2}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_load", {31'd0, mdr_load2}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_addr", {16'd0, mem_addr}, 32'd0);
    #1 rst = 1'b0;
    idle(3);
    chk("rst_no_done", done_cnt - d0, 32'd0);
    chk("rst_mdr_kept", {16'd0, mdr}, {16'd0, m0});
    xact(1'b0, 16'h0066, 16'hA5A5, 2, 1'b0, c0);
    chk("post_rst_mdr", {16'd0, mdr}, 32'h0000A5A5);

    // Ack never arrives for ten ACCESS cycles.
    m0 = mdr; r0 = rd_cnt; e0 = err_cnt;
    xact(1'b0, 16'h0300, 16'hCAFE, 10, 1'b0, c0);
`ifdef MEM_BUS_TIMEOUT_EN
    chk("to_strobes", rd_cnt - r0, 32'd4);
    chk("to_done_lat", last_done - c0, 32'd5);
    chk("to_errs", err_cnt - e0, 32'd1);
    chk("to_mdr", {16'd0, mdr}, {16'd0, m0});
`else
    chk("to_strobes", rd_cnt - r0, 32'd10);
    chk("to_done_lat", last_done - c0, 32'd12);
    chk("to_errs", err_cnt - e0, 32'd0);
    chk("to_mdr", {16'd0, mdr}, 32'h0000CAFE);
`endif

    // Stray acks in IDLE.
    d0 = done_cnt;
    idle(6);
    chk("stray_ack_dones", done_cnt - d0, 32'd0);

    // Random traffic, including back-to-back requests.
    d0 = done_cnt;
    for (int n = 0; n < 40; n++) begin
      v = 16'($urandom);
      if ($urandom % 2) begin
        set_mdr(16'($urandom));
        xact(1'b1, v, 16'h0, int'($urandom_range(1, 6)), bit'($urandom % 2), c0);
      end else begin
        xact(1'b0, v, 16'($urandom), int'($urandom_range(1, 6)), bit'($urandom % 2), c0);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    chk("rand_dones", done_cnt - d0, 32'd40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
